bsg_cache_nb_dma_to_wormhole: RTL and testbench

Cache-side DMA-to-wormhole bridge. It sits between one bsg_cache_nb DMA port and the wormhole network, directly upstream of the DMA fanout (wormhole-to-cache-DMA) block.
- Outbound: serializes each cache DMA packet, plus any evict data, into a wormhole packet (header, addr, optional mask, data).
- Inbound: receives fill packets (header, then data beats) and returns the data to the cache, tagged with the header's mshr_id.

---
 rtl/bsg_cache_nb_dma_to_wormhole.sv | 235 +++++++++++++++++++++++
 tb/tb_bsg_cache_nb_dma_to_wormhole.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_nb_dma_to_wormhole.sv
// Cache-side bridge: serializes bsg_cache_nb DMA packets (plus evict data) onto a wormhole link
// and returns inbound fill data to the cache tagged with the fill header's mshr_id.
module bsg_cache_nb_dma_to_wormhole
  #(parameter int dma_addr_width_p  = 32
   ,parameter int dma_burst_len_p   = 8
   ,parameter int dma_mask_width_p  = 8
   ,parameter int vcache_mshr_els_p = 4
   ,parameter int wh_flit_width_p   = 64
   ,parameter int wh_cid_width_p    = 2
   ,parameter int wh_len_width_p    = 4
   ,parameter int wh_cord_width_p   = 8
   ,localparam int lg_vcache_mshr_els_lp = (vcache_mshr_els_p > 1) ? $clog2(vcache_mshr_els_p) : 1
   ,localparam int dma_pkt_width_lp = 1 + dma_addr_width_p + dma_mask_width_p + lg_vcache_mshr_els_lp
   ,localparam int wh_link_sif_width_lp = wh_flit_width_p + 2
   )
  (input  logic                             clk_i
   ,input  logic                            reset_i
   ,input  logic [dma_pkt_width_lp-1:0]     dma_pkt_i
   ,input  logic                            dma_pkt_v_i
   ,output logic                            dma_pkt_yumi_o
   ,input  logic [wh_flit_width_p-1:0]      dma_data_i
   ,input  logic                            dma_data_v_i
   ,output logic                            dma_data_yumi_o
   ,output logic [wh_flit_width_p-1:0]      dma_data_o
   ,output logic [lg_vcache_mshr_els_lp-1:0] dma_data_mshr_id_o
   ,output logic                            dma_data_v_o
   ,input  logic                            dma_data_ready_and_i
   ,input  logic [wh_cord_width_p-1:0]      my_wh_cord_i
   ,input  logic [wh_cid_width_p-1:0]       my_wh_cid_i
   ,input  logic [wh_cord_width_p-1:0]      dest_wh_cord_i
   ,input  logic [wh_cid_width_p-1:0]       dest_wh_cid_i
   ,input  logic [wh_link_sif_width_lp-1:0] wh_link_sif_i
   ,output logic [wh_link_sif_width_lp-1:0] wh_link_sif_o
   );

   localparam int lg_burst_lp     = (dma_burst_len_p > 1) ? $clog2(dma_burst_len_p) : 1;
   // Header layout, LSB first: cord, len, cid, src_cord, src_cid, opcode, mshr_id, unused.
   localparam int len_off_lp      = wh_cord_width_p;
   localparam int cid_off_lp      = len_off_lp + wh_len_width_p;
   localparam int src_cord_off_lp = cid_off_lp + wh_cid_width_p;
   localparam int src_cid_off_lp  = src_cord_off_lp + wh_cord_width_p;
   localparam int op_off_lp       = src_cid_off_lp + wh_cid_width_p;
   localparam int mshr_off_lp     = op_off_lp + 2;
   localparam int hdr_used_lp     = mshr_off_lp + lg_vcache_mshr_els_lp;
   localparam logic [lg_burst_lp-1:0] last_beat_lp = lg_burst_lp'(dma_burst_len_p - 1);

   if (wh_flit_width_p < dma_addr_width_p || wh_flit_width_p < dma_mask_width_p) begin : g_err_flit
      $error("wh_flit_width_p must cover dma address and mask widths");
   end
   if (wh_len_width_p < $clog2(dma_burst_len_p + 3)) begin : g_err_len
      $error("wh_len_width_p too narrow for dma_burst_len_p+2");
   end
   if (hdr_used_lp > wh_flit_width_p) begin : g_err_hdr
      $error("header fields do not fit in one flit");
   end

   typedef enum logic [2:0] {S_IDLE, S_HEADER, S_ADDR, S_MASK, S_DATA} send_state_e;
   typedef enum logic {R_HEADER, R_DATA} recv_state_e;
   typedef enum logic [1:0] {OP_READ, OP_WRITE_NON_MASKED, OP_WRITE_MASKED} wh_op_e;

   // Link unpack: {v, data, then_ready_rev} in, {v, data, ready_and_rev} out.
   logic                       in_v, then_ready_rev;
   logic [wh_flit_width_p-1:0] in_data;
   assign in_v           = wh_link_sif_i[wh_flit_width_p+1];
   assign in_data        = wh_link_sif_i[wh_flit_width_p:1];
   assign then_ready_rev = wh_link_sif_i[0];

   logic                              pkt_wnr;
   logic [dma_addr_width_p-1:0]       pkt_addr;
   logic [dma_mask_width_p-1:0]       pkt_mask;
   logic [lg_vcache_mshr_els_lp-1:0]  pkt_mshr;
   assign pkt_wnr  = dma_pkt_i[dma_pkt_width_lp-1];
   assign pkt_addr = dma_pkt_i[lg_vcache_mshr_els_lp+dma_mask_width_p +: dma_addr_width_p];
   assign pkt_mask = dma_pkt_i[lg_vcache_mshr_els_lp +: dma_mask_width_p];
   assign pkt_mshr = dma_pkt_i[0 +: lg_vcache_mshr_els_lp];

   send_state_e                      send_state_r, send_state_n;
   logic [lg_burst_lp-1:0]           send_cnt_r, send_cnt_n;
   wh_op_e                           op_r;
   logic [dma_addr_width_p-1:0]      addr_r;
   logic [dma_mask_width_p-1:0]      mask_r;
   logic [lg_vcache_mshr_els_lp-1:0] pkt_mshr_id_r;
   logic                             send_v, pkt_yumi, data_yumi;
   logic [wh_flit_width_p-1:0]       send_data, header;
   logic [wh_len_width_p-1:0]        hdr_len;

   always_comb begin
      unique case (op_r)
         OP_READ:             hdr_len = wh_len_width_p'(1);
         OP_WRITE_NON_MASKED: hdr_len = wh_len_width_p'(1 + dma_burst_len_p);
         default:             hdr_len = wh_len_width_p'(2 + dma_burst_len_p);
      endcase
      header = '0;
      header[0 +: wh_cord_width_p]                   = dest_wh_cord_i;
      header[len_off_lp +: wh_len_width_p]           = hdr_len;
      header[cid_off_lp +: wh_cid_width_p]           = dest_wh_cid_i;
      header[src_cord_off_lp +: wh_cord_width_p]     = my_wh_cord_i;
      header[src_cid_off_lp +: wh_cid_width_p]       = my_wh_cid_i;
      header[op_off_lp +: 2]                         = op_r;
      header[mshr_off_lp +: lg_vcache_mshr_els_lp]   = pkt_mshr_id_r;
   end

   always_comb begin
      send_state_n = send_state_r;
      send_cnt_n   = send_cnt_r;
      send_v       = 1'b0;
      send_data    = '0;
      pkt_yumi     = 1'b0;
      data_yumi    = 1'b0;
      unique case (send_state_r)
         S_IDLE: begin
            pkt_yumi = dma_pkt_v_i;
            if (dma_pkt_v_i) send_state_n = S_HEADER;
         end
         S_HEADER: begin
            send_v    = 1'b1;
            send_data = header;
            if (then_ready_rev) send_state_n = S_ADDR;
         end
         S_ADDR: begin
            send_v    = 1'b1;
            send_data = wh_flit_width_p'(addr_r);
            if (then_ready_rev) begin
               unique case (op_r)
                  OP_READ:         send_state_n = S_IDLE;
                  OP_WRITE_MASKED: send_state_n = S_MASK;
                  default:         send_state_n = S_DATA;
               endcase
            end
         end
         S_MASK: begin
            send_v    = 1'b1;
            send_data = wh_flit_width_p'(mask_r);
            if (then_ready_rev) send_state_n = S_DATA;
         end
         S_DATA: begin
            send_v    = dma_data_v_i;
            send_data = dma_data_i;
            data_yumi = then_ready_rev & dma_data_v_i;
            if (data_yumi) begin
               if (send_cnt_r == last_beat_lp) begin
                  send_cnt_n   = '0;
                  send_state_n = S_IDLE;
               end else begin
                  send_cnt_n = send_cnt_r + 1'b1;
               end
            end
         end
         default: send_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         send_state_r  <= S_IDLE;
         send_cnt_r    <= '0;
         op_r          <= OP_READ;
         addr_r        <= '0;
         mask_r        <= '0;
         pkt_mshr_id_r <= '0;
      end else begin
         send_state_r <= send_state_n;
         send_cnt_r   <= send_cnt_n;
         if (pkt_yumi) begin
            op_r          <= !pkt_wnr ? OP_READ : ((&pkt_mask) ? OP_WRITE_NON_MASKED : OP_WRITE_MASKED);
            addr_r        <= pkt_addr;
            mask_r        <= pkt_mask;
            pkt_mshr_id_r <= pkt_mshr;
         end
      end
   end

   recv_state_e                      recv_state_r, recv_state_n;
   logic [lg_burst_lp-1:0]           recv_cnt_r, recv_cnt_n;
   logic [lg_vcache_mshr_els_lp-1:0] mshr_id_r;
   logic                             recv_ready, fill_v;
   logic [wh_len_width_p-1:0]        in_hdr_len;
   assign in_hdr_len = in_data[len_off_lp +: wh_len_width_p];

   always_comb begin
      recv_state_n = recv_state_r;
      recv_cnt_n   = recv_cnt_r;
      recv_ready   = 1'b0;
      fill_v       = 1'b0;
      unique case (recv_state_r)
         R_HEADER: begin
            recv_ready = 1'b1;
            if (in_v) recv_state_n = R_DATA;
         end
         R_DATA: begin
            fill_v     = in_v;
            recv_ready = dma_data_ready_and_i;
            if (in_v & dma_data_ready_and_i) begin
               if (recv_cnt_r == last_beat_lp) begin
                  recv_cnt_n   = '0;
                  recv_state_n = R_HEADER;
               end else begin
                  recv_cnt_n = recv_cnt_r + 1'b1;
               end
            end
         end
         default: recv_state_n = R_HEADER;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         recv_state_r <= R_HEADER;
         recv_cnt_r   <= '0;
         mshr_id_r    <= '0;
      end else begin
         recv_state_r <= recv_state_n;
         recv_cnt_r   <= recv_cnt_n;
         if (recv_state_r == R_HEADER && in_v)
            mshr_id_r <= in_data[mshr_off_lp +: lg_vcache_mshr_els_lp];
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!reset_i && recv_state_r == R_HEADER && in_v)
         assert (in_hdr_len == wh_len_width_p'(dma_burst_len_p))
            else $error("fill header len %0d, expected %0d", in_hdr_len, dma_burst_len_p);
   end
`endif

   // Handshake outputs are forced low while reset is asserted, independent of state.
   assign dma_pkt_yumi_o     = pkt_yumi & ~reset_i;
   assign dma_data_yumi_o    = data_yumi & ~reset_i;
   assign dma_data_v_o       = fill_v & ~reset_i;
   assign dma_data_o         = in_data;
   assign dma_data_mshr_id_o = mshr_id_r;
   assign wh_link_sif_o      = {send_v & ~reset_i, send_data, recv_ready & ~reset_i};

endmodule

// File: tb/tb_bsg_cache_nb_dma_to_wormhole.sv
// Directed bench for bsg_cache_nb_dma_to_wormhole: outbound read/write serialization,
// inbound fills with backpressure, concurrent send/receive, and asynchronous reset mid-packet.
module tb_bsg_cache_nb_dma_to_wormhole;

   localparam logic [7:0] dest_cord_c = 8'h5A;
   localparam logic [1:0] dest_cid_c  = 2'h1;
   localparam logic [7:0] my_cord_c   = 8'hC3;
   localparam logic [1:0] my_cid_c    = 2'h2;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [42:0] dma_pkt_i;
   logic        dma_pkt_v_i, dma_pkt_yumi_o;
   logic [63:0] dma_data_i;
   logic        dma_data_v_i, dma_data_yumi_o;
   logic [63:0] dma_data_o;
   logic [1:0]  dma_data_mshr_id_o;
   logic        dma_data_v_o, dma_data_ready_and_i;
   logic [65:0] wh_link_sif_i, wh_link_sif_o;

   logic        in_v, then_ready;
   logic [63:0] in_data;
   logic        out_v, out_rdy;
   logic [63:0] out_data;
   assign wh_link_sif_i = {in_v, in_data, then_ready};
   assign out_v    = wh_link_sif_o[65];
   assign out_data = wh_link_sif_o[64:1];
   assign out_rdy  = wh_link_sif_o[0];

   int n_compared = 0;
   int n_mismatched = 0;
   int tx_beats = 0;
   logic [63:0] exp_q[$];

   bsg_cache_nb_dma_to_wormhole dut
     (.clk_i(clk_i), .reset_i(reset_i)
      ,.dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o)
      ,.dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o)
      ,.dma_data_o(dma_data_o), .dma_data_mshr_id_o(dma_data_mshr_id_o)
      ,.dma_data_v_o(dma_data_v_o), .dma_data_ready_and_i(dma_data_ready_and_i)
      ,.my_wh_cord_i(my_cord_c), .my_wh_cid_i(my_cid_c)
      ,.dest_wh_cord_i(dest_cord_c), .dest_wh_cid_i(dest_cid_c)
      ,.wh_link_sif_i(wh_link_sif_i), .wh_link_sif_o(wh_link_sif_o));

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk_hdr(input logic [3:0] len, input logic [1:0] op,
                                          input logic [1:0] mshr, input logic [7:0] cord,
                                          input logic [1:0] cid, input logic [7:0] scord,
                                          input logic [1:0] scid);
      logic [63:0] h;
      h = '0;
      h[7:0] = cord; h[11:8] = len; h[13:12] = cid; h[21:14] = scord;
      h[23:22] = scid; h[25:24] = op; h[27:26] = mshr;
      return h;
   endfunction

   // Sends one DMA packet and checks every accepted outbound flit in order.
   task automatic send_pkt(input string tag, input logic wnr, input logic [31:0] addr,
                           input logic [7:0] mask, input logic [1:0] mshr,
                           input logic [63:0] dbase, input int stall_beat, input int stall_len);
      logic [1:0] op; logic [3:0] len;
      int beat, stalls; bit accepted, stalled;
      op  = !wnr ? 2'd0 : ((&mask) ? 2'd1 : 2'd2);
      len = !wnr ? 4'd1 : ((&mask) ? 4'd9 : 4'd10);
      exp_q.push_back(mk_hdr(len, op, mshr, dest_cord_c, dest_cid_c, my_cord_c, my_cid_c));
      exp_q.push_back(64'(addr));
      if (op == 2'd2) exp_q.push_back(64'(mask));
      if (wnr) for (int i = 0; i < 8; i++) exp_q.push_back(dbase + 64'(i));
      beat = 0; stalls = 0; accepted = 0; tx_beats = 0;
      dma_pkt_i = {wnr, addr, mask, mshr};
      dma_pkt_v_i = 1'b1;
      for (int cyc = 0; cyc < 300 && exp_q.size() != 0; cyc++) begin
         stalled = (beat == stall_beat) && (stalls < stall_len);
         then_ready   = !stalled;
         dma_data_v_i = wnr && (beat < 8);
         dma_data_i   = dbase + 64'(beat);
         @(negedge clk_i);
         if (dma_pkt_yumi_o) accepted = 1;
         if (out_v && then_ready && exp_q.size() != 0) check({tag, "_flit"}, out_data, exp_q.pop_front());
         if (dma_data_yumi_o) begin beat++; tx_beats = beat; end
         if (stalled) stalls++;
         @(posedge clk_i); #1;
         if (accepted) dma_pkt_v_i = 1'b0;
      end
      check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_yumis"}, 64'(beat), wnr ? 64'd8 : 64'd0);
      exp_q.delete();
      then_ready = 1'b1; dma_data_v_i = 1'b0;
      @(negedge clk_i);
      check({tag, "_end_v"}, 64'(out_v), 64'd0);
      @(posedge clk_i); #1;
   endtask

   // Delivers a fill header then 8 beats; optionally toggles the cache-side ready.
   task automatic recv_fill(input string tag, input logic [1:0] mshr,
                            input logic [63:0] dbase, input bit toggle);
      int beat; logic rdy;
      in_v = 1'b1;
      in_data = mk_hdr(4'd8, 2'd0, mshr, my_cord_c, my_cid_c, dest_cord_c, dest_cid_c);
      @(negedge clk_i);
      check({tag, "_hdr_rdy"}, 64'(out_rdy), 64'd1);
      @(posedge clk_i); #1;
      beat = 0;
      for (int cyc = 0; cyc < 100 && beat < 8; cyc++) begin
         rdy = toggle ? ((cyc % 2) == 1) : 1'b1;
         dma_data_ready_and_i = rdy;
         in_data = dbase + 64'(beat);
         @(negedge clk_i);
         check({tag, "_rdy"}, 64'(out_rdy), 64'(rdy));
         if (dma_data_v_o && rdy) begin
            check({tag, "_data"}, dma_data_o, dbase + 64'(beat));
            check({tag, "_mshr"}, 64'(dma_data_mshr_id_o), 64'(mshr));
            beat++;
         end
         @(posedge clk_i); #1;
      end
      in_v = 1'b0; dma_data_ready_and_i = 1'b0;
      check({tag, "_beats"}, 64'(beat), 64'd8);
      @(negedge clk_i);
      check({tag, "_rstate"}, 64'(dut.recv_state_r), 64'd0);
      check({tag, "_dv_off"}, 64'(dma_data_v_o), 64'd0);
      @(posedge clk_i); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int beat; bit acc;
      reset_i = 1'b1; dma_pkt_i = '0; dma_pkt_v_i = 1'b1; dma_data_i = '0; dma_data_v_i = 1'b0;
      dma_data_ready_and_i = 1'b1; in_v = 1'b0; in_data = '0; then_ready = 1'b1;
      #2;
      check("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
      check("rst_wh_rdy", 64'(out_rdy), 64'd0);
      check("rst_out_v", 64'(out_v), 64'd0);
      repeat (3) @(posedge clk_i);
      #1 dma_pkt_v_i = 1'b0; reset_i = 1'b0;
      @(negedge clk_i);
      check("rst_sstate", 64'(dut.send_state_r), 64'd0);
      check("rst_wh_rdy_after", 64'(out_rdy), 64'd1);
      @(posedge clk_i); #1;

      // Read with exact per-cycle timing.
      dma_pkt_i = {1'b0, 32'h1000, 8'h00, 2'd2}; dma_pkt_v_i = 1'b1;
      @(negedge clk_i);
      check("rd_c0_yumi", 64'(dma_pkt_yumi_o), 64'd1);
      check("rd_c0_v", 64'(out_v), 64'd0);
      @(posedge clk_i); #1 dma_pkt_v_i = 1'b0;
      @(negedge clk_i);
      check("rd_c1_v", 64'(out_v), 64'd1);
      check("rd_c1_hdr", out_data, mk_hdr(4'd1, 2'd0, 2'd2, dest_cord_c, dest_cid_c, my_cord_c, my_cid_c));
      @(negedge clk_i);
      check("rd_c2_addr", out_data, 64'h1000);
      @(negedge clk_i);
      check("rd_c3_v", 64'(out_v), 64'd0);
      check("rd_c3_idle", 64'(dut.send_state_r), 64'd0);
      @(posedge clk_i); #1;

      send_pkt("nmw", 1'b1, 32'h2000, 8'hFF, 2'd1, 64'd0, -1, 0);
      send_pkt("mw", 1'b1, 32'h2040, 8'h0F, 2'd3, 64'h100, -1, 0);
      recv_fill("fill3", 2'd3, 64'hF000, 1'b1);
      recv_fill("fill1", 2'd1, 64'hE000, 1'b0);

      // Fill arriving while a write is stalled mid-data.
      tx_beats = 0;
      fork
         send_pkt("cw", 1'b1, 32'h4000, 8'hFF, 2'd0, 64'h200, 3, 14);
         begin
            for (int i = 0; i < 100 && tx_beats < 3; i++) @(posedge clk_i);
            #1 recv_fill("cfill", 2'd2, 64'hD000, 1'b0);
         end
      join

      // Asynchronous reset during data beat 4.
      dma_pkt_i = {1'b1, 32'h3000, 8'hFF, 2'd1}; dma_pkt_v_i = 1'b1; then_ready = 1'b1;
      beat = 0; acc = 0;
      for (int cyc = 0; cyc < 100 && beat < 4; cyc++) begin
         dma_data_v_i = 1'b1; dma_data_i = 64'h300 + 64'(beat);
         @(negedge clk_i);
         if (dma_pkt_yumi_o) acc = 1;
         if (dma_data_yumi_o) beat++;
         @(posedge clk_i); #1;
         if (acc) dma_pkt_v_i = 1'b0;
      end
      dma_pkt_v_i = 1'b1; dma_data_ready_and_i = 1'b1; in_v = 1'b1;
      in_data = mk_hdr(4'd8, 2'd0, 2'd1, my_cord_c, my_cid_c, dest_cord_c, dest_cid_c);
      #1;
      check("ar_pre_cnt", 64'(dut.send_cnt_r), 64'd4);
      check("ar_pre_yumi", 64'(dma_data_yumi_o), 64'd1);
      reset_i = 1'b1;
      #1;
      check("ar_out_v", 64'(out_v), 64'd0);
      check("ar_data_yumi", 64'(dma_data_yumi_o), 64'd0);
      check("ar_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
      check("ar_wh_rdy", 64'(out_rdy), 64'd0);
      check("ar_fill_v", 64'(dma_data_v_o), 64'd0);
      @(posedge clk_i); #1;
      dma_pkt_v_i = 1'b0; dma_data_v_i = 1'b0; in_v = 1'b0; reset_i = 1'b0;
      @(negedge clk_i);
      check("ar_sstate", 64'(dut.send_state_r), 64'd0);
      check("ar_rstate", 64'(dut.recv_state_r), 64'd0);
      check("ar_scnt", 64'(dut.send_cnt_r), 64'd0);
      check("ar_rcnt", 64'(dut.recv_cnt_r), 64'd0);
      @(posedge clk_i); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
